// File: rtl/adder_sched_pkg.sv
// Shared defaults and helpers for the round-robin adder scheduler.
// Imported by the add_pipe datapath and the adder_rr_sched top.
package adder_sched_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NREQ  = 4;
    localparam int DEF_LAT   = 2;

    // At least one bit, so a single requester still has an id port.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/add_pipe.sv
// LAT-stage registered adder carrying a valid bit and an id tag.
// The result fields read as zero whenever the last stage holds no valid op.
module add_pipe
    import adder_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDW   = id_width(DEF_NREQ),
    parameter int LAT   = DEF_LAT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [IDW-1:0]   in_id,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    output logic [IDW-1:0]   out_id,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    logic [LAT-1:0] v_q, v_d;
    logic [IDW-1:0] id_q [LAT];
    logic [IDW-1:0] id_d [LAT];
    logic [WIDTH:0] s_q  [LAT];
    logic [WIDTH:0] s_d  [LAT];

    always_comb begin
        v_d[0]  = in_valid;
        id_d[0] = in_valid ? in_id : '0;
        s_d[0]  = in_valid ? ({1'b0, in_a} + {1'b0, in_b}) : '0;
        for (int i = 1; i < LAT; i++) begin
            v_d[i]  = v_q[i-1];
            id_d[i] = id_q[i-1];
            s_d[i]  = s_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                id_q[i] <= '0;
                s_q[i]  <= '0;
            end
        end else begin
            v_q <= v_d;
            for (int i = 0; i < LAT; i++) begin
                id_q[i] <= id_d[i];
                s_q[i]  <= s_d[i];
            end
        end
    end

    assign out_valid = v_q[LAT-1];
    assign out_id    = out_valid ? id_q[LAT-1] : '0;
    assign out_sum   = out_valid ? s_q[LAT-1][WIDTH-1:0] : '0;
    assign out_cout  = out_valid ? s_q[LAT-1][WIDTH] : 1'b0;

endmodule

// File: rtl/adder_rr_sched.sv
// Round-robin arbiter in front of a pipelined adder, with in-flight
// and accepted-op counters.
module adder_rr_sched
    import adder_sched_pkg::*;
#(
    parameter int  WIDTH = DEF_WIDTH,
    parameter int  NREQ  = DEF_NREQ,
    parameter int  LAT   = DEF_LAT,
    localparam int IDW   = id_width(NREQ),
    localparam int IFW   = $clog2(LAT + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic [IFW-1:0]        inflight,
    output logic [15:0]           op_count
);

    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IFW-1:0]   infl_q, infl_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   win_id;
    logic             found;
    logic             fire;
    logic [WIDTH-1:0] a_sel, b_sel;
    int               idx;

    // First valid requester at or after ptr, wrapping.
    always_comb begin
        grant  = '0;
        win_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                grant[idx] = 1'b1;
                win_id     = IDW'(idx);
                found      = 1'b1;
            end
        end
    end

    assign req_ready = (en && !reset) ? grant : '0;
    assign fire      = en && !reset && found;
    assign a_sel     = req_a[int'(win_id)*WIDTH +: WIDTH];
    assign b_sel     = req_b[int'(win_id)*WIDTH +: WIDTH];

    always_comb begin
        ptr_d  = ptr_q;
        infl_d = infl_q;
        cnt_d  = cnt_q;
        if (fire) begin
            ptr_d = (int'(win_id) == NREQ - 1) ? '0 : win_id + 1'b1;
            cnt_d = cnt_q + 16'd1;
        end
        if (fire && !rsp_valid) begin
            infl_d = infl_q + 1'b1;
        end else if (!fire && rsp_valid) begin
            infl_d = infl_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q  <= '0;
            infl_q <= '0;
            cnt_q  <= '0;
        end else begin
            ptr_q  <= ptr_d;
            infl_q <= infl_d;
            cnt_q  <= cnt_d;
        end
    end

    assign inflight = infl_q;
    assign op_count = cnt_q;

    add_pipe #(
        .WIDTH (WIDTH),
        .IDW   (IDW),
        .LAT   (LAT)
    ) u_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (fire),
        .in_id     (win_id),
        .in_a      (a_sel),
        .in_b      (b_sel),
        .out_valid (rsp_valid),
        .out_id    (rsp_id),
        .out_sum   (rsp_sum),
        .out_cout  (rsp_cout)
    );

endmodule

// File: tb/tb_adder_rr_sched.sv
// Randomized and directed bench for adder_rr_sched against a
// queue-based reference model of grants and responses.
module tb_adder_rr_sched;

    localparam int W = 8;
    localparam int N = 4;
    localparam int L = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic [N-1:0]  req_valid;
    logic [N*W-1:0] req_a, req_b;
    logic [N-1:0]  req_ready;
    logic          rsp_valid;
    logic [1:0]    rsp_id;
    logic [W-1:0]  rsp_sum;
    logic          rsp_cout;
    logic [1:0]    inflight;
    logic [15:0]   op_count;

    adder_rr_sched #(.WIDTH(W), .NREQ(N), .LAT(L)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .inflight  (inflight),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v;
        int id;
        int sum;
        int cout;
    } rsp_t;

    rsp_t exp_q[$];
    int   m_ptr;
    int   m_cnt;
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic void model_clear();
        rsp_t e;
        e = '{v: 1'b0, id: 0, sum: 0, cout: 0};
        exp_q.delete();
        for (int i = 0; i < L; i++) exp_q.push_back(e);
        m_ptr = 0;
        m_cnt = 0;
    endfunction

    // One cycle: drive, check at negedge, advance model, cross the edge.
    task automatic cyc(input logic [N-1:0] v, input logic [31:0] a,
                       input logic [31:0] b, input logic e);
        rsp_t ex, nx;
        int   infl, win, s, ai, bi;
        bit   hit;
        req_valid = v;
        req_a     = a;
        req_b     = b;
        en        = e;
        @(negedge clk);
        infl = 0;
        foreach (exp_q[i]) if (exp_q[i].v) infl++;
        ex = exp_q.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'(ex.v));
        chk("rsp_id", 32'(rsp_id), 32'(ex.id));
        chk("rsp_sum", 32'(rsp_sum), 32'(ex.sum));
        chk("rsp_cout", 32'(rsp_cout), 32'(ex.cout));
        chk("inflight", 32'(inflight), 32'(infl));
        chk("op_count", 32'(op_count), 32'(m_cnt));
        hit = 1'b0;
        win = 0;
        if (e) begin
            for (int k = 0; k < N; k++) begin
                if (!hit && v[(m_ptr + k) % N]) begin
                    win = (m_ptr + k) % N;
                    hit = 1'b1;
                end
            end
        end
        chk("req_ready", 32'(req_ready), hit ? (32'd1 << win) : 32'd0);
        nx = '{v: 1'b0, id: 0, sum: 0, cout: 0};
        if (hit) begin
            ai = int'((a >> (win * W)) & 32'hFF);
            bi = int'((b >> (win * W)) & 32'hFF);
            s  = ai + bi;
            nx = '{v: 1'b1, id: win, sum: s % 256, cout: s / 256};
            m_ptr = (win + 1) % N;
            m_cnt = (m_cnt + 1) % 65536;
        end
        exp_q.push_back(nx);
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; reset asserts mid-cycle.
    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '1;
        en        = 1'b1;
        #2;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_sum", 32'(rsp_sum), 32'd0);
        chk("rst_inflight", 32'(inflight), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        reset     = 1'b1;
        en        = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        cyc(4'b0001, 32'h0000_0012, 32'h0000_0034, 1'b1);
        cyc(4'b0000, 32'h0, 32'h0, 1'b1);
        chk("d_valid", 32'(rsp_valid), 32'd1);
        chk("d_id0", 32'(rsp_id), 32'd0);
        chk("d_sum46", 32'(rsp_sum), 32'h46);
        chk("d_cout0", 32'(rsp_cout), 32'd0);
        cyc(4'b0000, 32'h0, 32'h0, 1'b1);

        cyc(4'b0100, 32'h00FF_0000, 32'h0001_0000, 1'b1);
        cyc(4'b0000, 32'h0, 32'h0, 1'b1);
        chk("ovf_id2", 32'(rsp_id), 32'd2);
        chk("ovf_sum0", 32'(rsp_sum), 32'd0);
        chk("ovf_cout1", 32'(rsp_cout), 32'd1);
        cyc(4'b0000, 32'h0, 32'h0, 1'b1);

        do_reset();
        for (int i = 0; i < 8; i++) cyc(4'b1111, $urandom, $urandom, 1'b1);
        chk("rr_opcnt8", 32'(op_count), 32'd8);
        repeat (3) cyc(4'b0000, 32'h0, 32'h0, 1'b1);

        cyc(4'b0011, $urandom, $urandom, 1'b1);
        cyc(4'b0011, $urandom, $urandom, 1'b1);
        repeat (3) cyc(4'b1111, $urandom, $urandom, 1'b0);
        chk("en0_drained", 32'(inflight), 32'd0);
        repeat (3) cyc(4'b1111, $urandom, $urandom, 1'b1);

        cyc(4'b1000, $urandom, $urandom, 1'b1);
        do_reset();
        repeat (4) cyc(4'b0000, 32'h0, 32'h0, 1'b1);
        chk("rstmid_op_count", 32'(op_count), 32'd0);

        for (int i = 0; i < 3000; i++)
            cyc(N'($urandom), $urandom, $urandom, $urandom_range(0, 4) != 0);

        do_reset();
        for (int i = 0; i < 65535; i++)
            cyc(4'b0001, $urandom, $urandom, 1'b1);
        chk("opcnt_ffff", 32'(op_count), 32'hFFFF);
        cyc(4'b0001, $urandom, $urandom, 1'b1);
        chk("opcnt_wrap", 32'(op_count), 32'h0);
        repeat (3) cyc(4'b0000, 32'h0, 32'h0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/adder_rr_sched.md
ADDER_RR_SCHED -- requirements
Module: adder_rr_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/sum width.
REQ-002 SHALL have parameter NREQ, default 4: number of requesters; IDW = clog2(NREQ).
REQ-003 SHALL have parameter LAT, default 2: pipeline latency, grant to response, in cycles.
REQ-004 clk  input  1  the only clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  high allows grants; low blocks new grants while in-flight ops drain.
REQ-007 req_valid  input  NREQ  per-requester request valid.
REQ-008 req_a  input  NREQ*WIDTH  operand a; requester i in bits [i*WIDTH +: WIDTH].
REQ-009 req_b  input  NREQ*WIDTH  operand b; same packing.
REQ-010 req_ready  output  NREQ  one-hot grant; at most one bit high per cycle.
REQ-011 rsp_valid  output  1  result valid.
REQ-012 rsp_id  output  IDW  requester index of the result.
REQ-013 rsp_sum  output  WIDTH  (a+b) mod 2^WIDTH.
REQ-014 rsp_cout  output  1  carry out of a+b.
REQ-015 inflight  output  clog2(LAT+1)  count of accepted, not yet returned ops.
REQ-016 op_count  output  16  total accepted ops; wraps 0xFFFF -> 0x0000.

Function
REQ-017 req_ready[i] SHALL be combinational from en, req_valid and rr pointer: high only for the round-robin winner, only when en=1.
REQ-018 Round-robin search SHALL start at pointer ptr, ascending index, wrapping NREQ-1 -> 0.
REQ-019 On a transfer (req_valid[i] & req_ready[i]), ptr SHALL become (i+1) mod NREQ; otherwise ptr SHALL hold.
REQ-020 Requesters SHALL hold req_valid and operands stable until granted; the block SHALL NOT require it for correctness: operands are sampled only in the transfer cycle.
REQ-021 Transfer at edge N SHALL produce rsp_valid=1 with matching rsp_id/rsp_sum/rsp_cout for exactly one cycle after edge N+LAT-1, i.e. visible in cycle N+LAT.
REQ-022 Back-to-back transfers SHALL be accepted every cycle (throughput 1/cycle); responses SHALL return in grant order.
REQ-023 No response backpressure exists; rsp_valid SHALL be a pure function of the tagged valid pipeline.
REQ-024 When rsp_valid=0, rsp_id, rsp_sum and rsp_cout SHALL be 0.
REQ-025 inflight SHALL increment on a transfer, decrement on a response, hold on both or neither; never exceeds LAT.
REQ-026 op_count SHALL increment by 1 per transfer, wrapping modulo 2^16.
REQ-027 Arithmetic SHALL be unsigned WIDTH+1 bit: {rsp_cout, rsp_sum} = a + b.
REQ-028 en falling with ops in flight SHALL still deliver all pending responses; en rising SHALL resume from current ptr.
REQ-029 A single requester asserting continuously with others idle SHALL be granted every cycle.

Reset
REQ-030 Reset SHALL asynchronously clear ptr to 0, all pipeline valid bits, inflight, op_count, and force rsp_valid, rsp_id, rsp_sum, rsp_cout to 0.
REQ-031 Reset asserted mid-operation SHALL discard in-flight ops; no response for them appears after release.
REQ-032 req_ready SHALL be 0 while reset is high.

Structure
REQ-033 Shared package adder_sched_pkg SHALL hold default WIDTH/NREQ/LAT constants and the id-width function.
REQ-034 Datapath SHALL be sub-module add_pipe: LAT-stage registered adder carrying valid and id tag alongside the sum.
REQ-035 Arbiter (ptr, one-hot grant) and counters SHALL live in adder_rr_sched top.

Verification
REQ-036 Reset release, req0 a=0x12 b=0x34 -> grant next cycle, 2 cycles later rsp_valid, id=0, sum=0x46, cout=0.
REQ-037 Overflow: a=0xFF b=0x01 from req2 -> sum=0x00, cout=1, id=2.
REQ-038 All four requesters valid for 8 cycles, ptr=0 -> grant order 0,1,2,3,0,1,2,3; responses same order, one per cycle; op_count=8.
REQ-039 en=0 with two ops in flight -> no grants, both responses delivered, inflight reaches 0; en=1 resumes at ptr.
REQ-040 Reset pulsed one cycle after a grant -> no rsp_valid afterwards; inflight=0, op_count=0.
REQ-041 Force op_count to 0xFFFF via 65535 transfers, one more transfer -> op_count=0x0000.
